// File: rtl/pin_entry_controller.sv
// pin_entry_controller: card / account / PIN entry sequencer
// with retry lockout, idle timeout and a registered error strobe.
module pin_entry_controller #(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        card_inserted,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        acc_found_stat,
  input  logic        acc_auth_stat,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic        session_ok,
  output logic        card_locked,
  output logic [1:0]  attempts_left,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_ACC = 3'd1,
    GET_PIN = 3'd2,
    CHECK   = 3'd3,
    AUTH_OK = 3'd4,
    LOCKED  = 3'd5
  } state_t;

  localparam logic [2:0] E_BAD_ACC = 3'd1;
  localparam logic [2:0] E_NO_ACC  = 3'd2;
  localparam logic [2:0] E_WRONG   = 3'd3;
  localparam logic [2:0] E_SHORT   = 3'd4;
  localparam logic [2:0] E_TIMEOUT = 3'd5;
  localparam logic [2:0] E_LOCKED  = 3'd6;

  localparam logic [1:0]  MAX_A    = 2'(MAX_ATTEMPTS);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  acc_q;
  logic [7:0]  acc_d;
  logic [1:0]  acc_cnt;
  logic [1:0]  acc_cnt_d;
  logic [3:0]  acc_num_d;
  logic [15:0] pin_d;
  logic [2:0]  pin_cnt;
  logic [2:0]  pin_cnt_d;
  logic [1:0]  fail_cnt;
  logic [1:0]  fail_d;
  logic [1:0]  fail_inc;
  logic [15:0] timer;
  logic [15:0] timer_d;
  logic        err_v_d;
  logic [2:0]  err_c_d;
  logic        wipe;

  logic k_dig;
  logic k_ent;
  logic k_clr;
  logic k_can;
  logic in_entry;
  logic tmo;
  logic acc_bad;

  assign k_dig    = key_valid && (key_code <= 4'd9);
  assign k_ent    = key_valid && (key_code == 4'hA);
  assign k_clr    = key_valid && (key_code == 4'hB);
  assign k_can    = key_valid && (key_code == 4'hC);
  assign in_entry = (state == GET_ACC) ||
                    (state == GET_PIN);
  // a key in the same cycle always wins over expiry
  assign tmo      = in_entry && !key_valid &&
                    (timer == TMO_LAST);
  assign acc_bad  = (acc_q == 8'd0) || (acc_q > 8'd15);
  assign fail_inc = fail_cnt + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!card_inserted) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: state_nxt = GET_ACC;
        GET_ACC: begin
          if (k_ent && acc_cnt != 2'd0 && !acc_bad)
            state_nxt = GET_PIN;
        end
        GET_PIN: begin
          if (tmo || k_can)
            state_nxt = GET_ACC;
          else if (k_ent && pin_cnt == 3'd4)
            state_nxt = CHECK;
        end
        CHECK: begin
          if (!acc_found_stat)     state_nxt = GET_ACC;
          else if (acc_auth_stat)  state_nxt = AUTH_OK;
          else if (fail_inc == MAX_A)
            state_nxt = LOCKED;
          else                     state_nxt = GET_PIN;
        end
        AUTH_OK: begin
          if (k_can) state_nxt = GET_ACC;
        end
        LOCKED:  state_nxt = LOCKED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt;
    acc_num_d = acc_num;
    pin_d     = pin;
    pin_cnt_d = pin_cnt;
    fail_d    = fail_cnt;
    timer_d   = '0;
    err_v_d   = 1'b0;
    err_c_d   = err_code;
    wipe      = 1'b0;
    if (!card_inserted) begin
      wipe   = 1'b1;
      fail_d = '0;
    end else if (in_entry) begin
      if (!key_valid) timer_d = timer + 16'd1;
      unique case (1'b1)
        tmo: begin
          timer_d = '0;
          wipe    = 1'b1;
          err_v_d = 1'b1;
          err_c_d = E_TIMEOUT;
        end
        k_can: wipe = 1'b1;
        k_clr: begin
          if (state == GET_ACC) begin
            acc_d     = '0;
            acc_cnt_d = '0;
          end else begin
            pin_d     = '0;
            pin_cnt_d = '0;
          end
        end
        k_dig: begin
          if (state == GET_ACC) begin
            if (acc_cnt < 2'd2) begin
              acc_d     = acc_q * 8'd10 + {4'd0, key_code};
              acc_cnt_d = acc_cnt + 2'd1;
            end
          end else if (pin_cnt < 3'd4) begin
            pin_d     = pin * 16'd10 + {12'd0, key_code};
            pin_cnt_d = pin_cnt + 3'd1;
          end
        end
        k_ent: begin
          if (state == GET_ACC) begin
            if (acc_cnt != 2'd0) begin
              if (acc_bad) begin
                acc_d     = '0;
                acc_cnt_d = '0;
                err_v_d   = 1'b1;
                err_c_d   = E_BAD_ACC;
              end else begin
                acc_num_d = acc_q[3:0];
              end
            end
          end else if (pin_cnt != 3'd4) begin
            err_v_d = 1'b1;
            err_c_d = E_SHORT;
          end
        end
        default: ;
      endcase
    end else if (state == CHECK) begin
      err_v_d = !acc_auth_stat || !acc_found_stat;
      if (!acc_found_stat) begin
        wipe    = 1'b1;
        err_c_d = E_NO_ACC;
      end else if (acc_auth_stat) begin
        fail_d = '0;
      end else begin
        fail_d    = fail_inc;
        pin_d     = '0;
        pin_cnt_d = '0;
        err_c_d   = (fail_inc == MAX_A) ? E_LOCKED : E_WRONG;
      end
    end else if (state == AUTH_OK && k_can) begin
      wipe = 1'b1;
    end
    if (wipe) begin
      acc_d     = '0;
      acc_cnt_d = '0;
      acc_num_d = '0;
      pin_d     = '0;
      pin_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      acc_cnt   <= '0;
      acc_num   <= '0;
      pin       <= '0;
      pin_cnt   <= '0;
      fail_cnt  <= '0;
      timer     <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
    end else begin
      acc_q     <= acc_d;
      acc_cnt   <= acc_cnt_d;
      acc_num   <= acc_num_d;
      pin       <= pin_d;
      pin_cnt   <= pin_cnt_d;
      fail_cnt  <= fail_d;
      timer     <= timer_d;
      err_valid <= err_v_d;
      err_code  <= err_c_d;
    end
  end

  always_comb begin
    session_ok    = (state == AUTH_OK);
    card_locked   = (state == LOCKED);
    attempts_left = (state == LOCKED) ? 2'd0
                                      : MAX_A - fail_cnt;
    state_dbg     = state;
  end

endmodule
